// File: rtl/td4_pkg.sv
// rtl/td4_pkg.sv - TD4 opcode, operand-select and field definitions
package td4_pkg;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_ADD_A    = 4'b0000,
    OP_MOV_A_B  = 4'b0001,
    OP_IN_A     = 4'b0010,
    OP_MOV_A_IM = 4'b0011,
    OP_MOV_B_A  = 4'b0100,
    OP_ADD_B    = 4'b0101,
    OP_IN_B     = 4'b0110,
    OP_MOV_B_IM = 4'b0111,
    OP_OUT_B    = 4'b1001,
    OP_OUT_IM   = 4'b1011,
    OP_JNC      = 4'b1110,
    OP_JMP      = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {SRC_A, SRC_B, SRC_IN, SRC_ZERO} src_sel_e;

  typedef enum logic [2:0] {DST_A, DST_B, DST_OUT, DST_PC, DST_NONE} dst_sel_e;

endpackage

// File: rtl/td4_decoder.sv
// rtl/td4_decoder.sv - combinational TD4 instruction decoder
module td4_decoder
  import td4_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       c,
  output src_sel_e   src_sel,
  output dst_sel_e   dst_sel,
  output logic       load_c,
  output logic       jump_taken
);

  always_comb begin
    src_sel    = SRC_ZERO;
    dst_sel    = DST_NONE;
    load_c     = 1'b1;
    jump_taken = 1'b0;
    case (opcode)
      OP_ADD_A:    begin src_sel = SRC_A;    dst_sel = DST_A;   end
      OP_MOV_A_B:  begin src_sel = SRC_B;    dst_sel = DST_A;   end
      OP_IN_A:     begin src_sel = SRC_IN;   dst_sel = DST_A;   end
      OP_MOV_A_IM: begin src_sel = SRC_ZERO; dst_sel = DST_A;   end
      OP_MOV_B_A:  begin src_sel = SRC_A;    dst_sel = DST_B;   end
      OP_ADD_B:    begin src_sel = SRC_B;    dst_sel = DST_B;   end
      OP_IN_B:     begin src_sel = SRC_IN;   dst_sel = DST_B;   end
      OP_MOV_B_IM: begin src_sel = SRC_ZERO; dst_sel = DST_B;   end
      OP_OUT_B:    begin src_sel = SRC_B;    dst_sel = DST_OUT; end
      OP_OUT_IM:   begin src_sel = SRC_ZERO; dst_sel = DST_OUT; end
      OP_JMP:      begin dst_sel = DST_PC; jump_taken = 1'b1;   end
      // JNC looks at the carry held before this edge
      OP_JNC:      begin dst_sel = DST_PC; jump_taken = ~c;     end
      default:     load_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/td4_core.sv
// rtl/td4_core.sv - TD4 execution core: registers, adder and PC
module td4_core
  import td4_pkg::*;
#(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [3:0] addr,
  input  logic [7:0] data,
  input  logic [3:0] in_port,
  output logic [3:0] out_port,
  output logic       carry
);

  logic [3:0] reg_a, reg_b, reg_out, pc;
  logic       c_flag;
  logic [3:0] imm, src;
  logic [4:0] sum;
  src_sel_e   src_sel;
  dst_sel_e   dst_sel;
  logic       load_c, jump_taken;

  assign imm = data[IMM_MSB:IMM_LSB];

  td4_decoder u_decoder (
    .opcode     (data[OPC_MSB:OPC_LSB]),
    .c          (c_flag),
    .src_sel    (src_sel),
    .dst_sel    (dst_sel),
    .load_c     (load_c),
    .jump_taken (jump_taken)
  );

  always_comb begin
    src = 4'h0;
    case (src_sel)
      SRC_A:   src = reg_a;
      SRC_B:   src = reg_b;
      SRC_IN:  src = in_port;
      default: src = 4'h0;
    endcase
  end

  assign sum = {1'b0, src} + {1'b0, imm};

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a   <= 4'h0;
      reg_b   <= 4'h0;
      reg_out <= 4'h0;
      c_flag  <= 1'b0;
      pc      <= RESET_PC;
    end else if (en) begin
      case (dst_sel)
        DST_A:   reg_a   <= sum[3:0];
        DST_B:   reg_b   <= sum[3:0];
        DST_OUT: reg_out <= sum[3:0];
        default: ;
      endcase
      if (load_c) c_flag <= sum[4];
      pc <= (dst_sel == DST_PC && jump_taken) ? sum[3:0] : pc + 4'd1;
    end
  end

  assign addr     = pc;
  assign out_port = reg_out;
  assign carry    = c_flag;

endmodule

// File: tb/tb_td4_core.sv
// tb/tb_td4_core.sv - directed self-checking bench for td4_core
module tb_td4_core;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] addr, in_port, out_port;
  logic [7:0] data;
  logic       carry;
  int         checks = 0;
  int         errors = 0;

  td4_core #(.RESET_PC(4'h0)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .addr     (addr),
    .data     (data),
    .in_port  (in_port),
    .out_port (out_port),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one rising edge with the current inputs, then settle before sampling
  task automatic step(input logic [7:0] instr);
    data = instr;
    @(posedge clk);
    #1;
  endtask

  task automatic state(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                       input logic [3:0] eo, input logic ec, input logic [3:0] epc);
    check({tag, "_a"}, {4'h0, dut.reg_a}, {4'h0, ea});
    check({tag, "_b"}, {4'h0, dut.reg_b}, {4'h0, eb});
    check({tag, "_out"}, {4'h0, out_port}, {4'h0, eo});
    check({tag, "_c"}, {7'h0, carry}, {7'h0, ec});
    check({tag, "_addr"}, {4'h0, addr}, {4'h0, epc});
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; in_port = 4'h0; data = 8'h3F;
    step(8'h3F);
    step(8'h3F);
    rst = 1'b0;
    state("reset", 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);
    step(8'h3F);
    state("mov_a_15", 4'hF, 4'h0, 4'h0, 1'b0, 4'h1);

    // add overflow then JNC not taken
    rst = 1'b1; step(8'h00); rst = 1'b0;
    step(8'h33);
    state("mov_a_3", 4'h3, 4'h0, 4'h0, 1'b0, 4'h1);
    step(8'h0F);
    state("add_ovf", 4'h2, 4'h0, 4'h0, 1'b1, 4'h2);
    step(8'hE0);
    state("jnc_nt", 4'h2, 4'h0, 4'h0, 1'b0, 4'h3);

    // JNC taken, then halt loop
    step(8'hE5);
    state("jnc_t", 4'h2, 4'h0, 4'h0, 1'b0, 4'h5);
    for (int i = 0; i < 10; i++) begin
      step(8'hF5);
      check("halt_addr", {4'h0, addr}, 8'h05);
    end
    check("halt_out", {4'h0, out_port}, 8'h00);

    // I/O
    in_port = 4'b1001;
    step(8'h60);
    step(8'h90);
    state("out_b", 4'h2, 4'h9, 4'h9, 1'b0, 4'h7);
    in_port = 4'h0;
    step(8'hB6);
    state("out_im", 4'h2, 4'h9, 4'h6, 1'b0, 4'h8);

    // PC wrap through a NOP with C=1
    step(8'hFE);
    check("jmp14", {4'h0, addr}, 8'h0E);
    step(8'h0F);
    state("add_at14", 4'h1, 4'h9, 4'h6, 1'b1, 4'hF);
    step(8'h8A);
    state("nop_wrap", 4'h1, 4'h9, 4'h6, 1'b1, 4'h0);
    step(8'hC3);
    state("nop_c", 4'h1, 4'h9, 4'h6, 1'b1, 4'h1);
    step(8'h7F);
    state("mov_b_15", 4'h1, 4'hF, 4'h6, 1'b0, 4'h2);
    step(8'h11);
    state("mov_a_b", 4'h0, 4'hF, 4'h6, 1'b1, 4'h3);

    // enable freeze, then reset while disabled
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_port = 4'(i + 3);
      step(8'h0F);
    end
    state("frozen", 4'h0, 4'hF, 4'h6, 1'b1, 4'h3);
    rst = 1'b1;
    step(8'h0F);
    rst = 1'b0;
    state("rst_en0", 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);

    // remaining source paths
    en = 1'b1; in_port = 4'hC;
    step(8'h25);
    state("in_a", 4'h1, 4'h0, 4'h0, 1'b1, 4'h1);
    in_port = 4'h0;
    step(8'h4F);
    state("mov_b_a", 4'h1, 4'h0, 4'h0, 1'b1, 4'h2);
    step(8'h53);
    state("add_b", 4'h1, 4'h3, 4'h0, 1'b0, 4'h3);
    step(8'h90);
    state("out_b2", 4'h1, 4'h3, 4'h3, 1'b0, 4'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
